path_uart_streamer: RTL

Serializes the selected population (output of the selection stage, NUM_PATHS paths of PATH_BITS each) onto a UART 8N1 line for host-side inspection. It sits downstream of selection, alongside mutation, and is triggered by the controller's transmit strobe once per generation. It snapshots the population on start, so upstream stages may proceed while it transmits.

---
 rtl/ga_uart_pkg.sv | 33 +++
 rtl/uart_tx_byte.sv | 114 +++++++++++
 rtl/path_uart_streamer.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/ga_uart_pkg.sv
// Shared definitions for the population UART debug port: frame header,
// state encodings and frame-size helpers.
package ga_uart_pkg;

  localparam logic [7:0] FRAME_HEADER = 8'hA5;

  // Bit-level serializer states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START_BIT,
    ST_DATA,
    ST_STOP,
    ST_DONE
  } uart_state_t;

  // Frame-level sequencing states.
  typedef enum logic [1:0] {
    FR_IDLE,
    FR_SEND,
    FR_DONE
  } frame_state_t;

  // Bytes needed to carry one path, upper byte zero padded.
  function automatic int bytes_per_path(input int path_bits);
    return (path_bits + 7) / 8;
  endfunction

  // Header plus, per path, one index byte and the path bytes.
  function automatic int frame_bytes(input int num_paths, input int path_bits);
    return 1 + num_paths * (1 + bytes_per_path(path_bits));
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// UART 8N1 byte serializer with a ready/valid input. A byte offered during
// the last cycle of the stop bit is taken immediately, so back-to-back bytes
// leave no idle gap on the line. tx is a register output.
module uart_tx_byte
  import ga_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  uart_state_t      state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]       bit_reg, bit_next;
  logic [7:0]       shift_reg, shift_next;
  logic             tx_reg, tx_next;
  logic             last_tick;

  assign last_tick = (cnt_reg == CNT_MAX);
  assign tx        = tx_reg;

  // State, bit-time counter, bit index, shifter and line register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      tx_reg    <= 1'b1;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      tx_reg    <= tx_next;
    end
  end

  // Next-state logic; the line value for the coming bit is decided here so tx stays registered.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    tx_next    = tx_reg;
    ready      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        ready   = 1'b1;
        tx_next = 1'b1;
        if (valid) begin
          shift_next = data;
          tx_next    = 1'b0;
          cnt_next   = '0;
          state_next = ST_START_BIT;
        end
      end
      ST_START_BIT: begin
        if (last_tick) begin
          cnt_next   = '0;
          bit_next   = '0;
          tx_next    = shift_reg[0];
          state_next = ST_DATA;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_DATA: begin
        if (last_tick) begin
          cnt_next = '0;
          if (bit_reg == 3'd7) begin
            tx_next    = 1'b1;
            state_next = ST_STOP;
          end else begin
            bit_next   = bit_reg + 1'b1;
            shift_next = {1'b0, shift_reg[7:1]};
            tx_next    = shift_reg[1];
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_STOP: begin
        if (last_tick) begin
          ready    = 1'b1;
          cnt_next = '0;
          if (valid) begin
            shift_next = data;
            tx_next    = 1'b0;
            state_next = ST_START_BIT;
          end else begin
            tx_next    = 1'b1;
            state_next = ST_IDLE;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: begin
        tx_next    = 1'b1;
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/path_uart_streamer.sv
// Streams a snapshot of the selected population over UART 8N1:
// header, then per path an index byte and the path bytes LSB-byte first.
// Optional feature macro: PATH_UART_CHECKSUM_EN appends an XOR checksum byte.
module path_uart_streamer
  import ga_uart_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int BAUD      = 115_200,
  parameter int NUM_PATHS = 10,
  parameter int PATH_BITS = 150
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [NUM_PATHS*PATH_BITS-1:0] sel_population,
  output logic                           tx,
  output logic                           busy,
  output logic                           done
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int BPP          = bytes_per_path(PATH_BITS);
`ifdef PATH_UART_CHECKSUM_EN
  localparam int CSUM_BYTES = 1;
`else
  localparam int CSUM_BYTES = 0;
`endif
  localparam int N_BYTES = frame_bytes(NUM_PATHS, PATH_BITS) + CSUM_BYTES;
  localparam int PTR_W   = $clog2(N_BYTES + 1);
  localparam int PATH_W  = (NUM_PATHS > 1) ? $clog2(NUM_PATHS) : 1;
  localparam int SLOT_W  = $clog2(BPP + 1);
  localparam int KIDX_W  = (BPP > 1) ? $clog2(BPP) : 1;

  if (CLKS_PER_BIT < 2) begin : g_baud_check
    $error("path_uart_streamer: CLK_HZ/BAUD must be at least 2");
  end

  frame_state_t                       state_reg, state_next;
  logic [PTR_W-1:0]                   ptr_reg, ptr_next;
  logic [PATH_W-1:0]                  path_reg, path_next;
  // slot 0 is the index byte, slot k+1 carries path byte k
  logic [SLOT_W-1:0]                  slot_reg, slot_next;
  logic [NUM_PATHS-1:0][BPP-1:0][7:0] snap_reg;
  logic [NUM_PATHS-1:0][BPP-1:0][7:0] padded;
  logic [KIDX_W-1:0]                  kidx;
  logic                               snap_load;
  logic [7:0]                         tx_data;
  logic                               tx_valid;
  logic                               tx_ready;

  // Zero-pad each path up to a whole number of bytes.
  for (genvar gi = 0; gi < NUM_PATHS; gi++) begin : g_pad
    assign padded[gi] = (BPP*8)'(sel_population[gi*PATH_BITS +: PATH_BITS]);
  end

  // Snapshot taken when a start is accepted; upstream may change freely afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) snap_reg <= '0;
    else if (snap_load) snap_reg <= padded;
  end

`ifdef PATH_UART_CHECKSUM_EN
  logic [7:0] csum_reg;

  // Running XOR of every byte handed to the serializer, restarted by the header.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) csum_reg <= '0;
    else if (tx_valid && tx_ready)
      csum_reg <= (state_reg == FR_IDLE) ? tx_data : (csum_reg ^ tx_data);
  end
`endif

  // Byte mux: header, checksum, index or path byte selected by the sequencing counters.
  always_comb begin
    kidx    = (slot_reg == '0) ? '0 : KIDX_W'(slot_reg - 1'b1);
    tx_data = FRAME_HEADER;
    if (ptr_reg == '0) tx_data = FRAME_HEADER;
`ifdef PATH_UART_CHECKSUM_EN
    else if (ptr_reg == PTR_W'(N_BYTES - 1)) tx_data = csum_reg;
`endif
    else if (slot_reg == '0) tx_data = 8'(path_reg);
    else tx_data = snap_reg[path_reg][kidx];
  end

  // Frame state and byte pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= FR_IDLE;
      ptr_reg   <= '0;
      path_reg  <= '0;
      slot_reg  <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      path_reg  <= path_next;
      slot_reg  <= slot_next;
    end
  end

  // Frame sequencing: hand bytes to the serializer and finish once the last stop bit ends.
  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    path_next  = path_reg;
    slot_next  = slot_reg;
    snap_load  = 1'b0;
    tx_valid   = 1'b0;
    case (state_reg)
      FR_IDLE: begin
        tx_valid = start;
        if (start && tx_ready) begin
          snap_load  = 1'b1;
          ptr_next   = PTR_W'(1);
          path_next  = '0;
          slot_next  = '0;
          state_next = FR_SEND;
        end
      end
      FR_SEND: begin
        tx_valid = (ptr_reg < PTR_W'(N_BYTES));
        if (tx_valid && tx_ready) begin
          ptr_next = ptr_reg + 1'b1;
          if (slot_reg == SLOT_W'(BPP)) begin
            slot_next = '0;
            if (path_reg != PATH_W'(NUM_PATHS - 1)) path_next = path_reg + 1'b1;
          end else begin
            slot_next = slot_reg + 1'b1;
          end
        end else if (tx_ready) begin
          state_next = FR_DONE;
        end
      end
      FR_DONE: begin
        ptr_next   = '0;
        state_next = FR_IDLE;
      end
      default: state_next = FR_IDLE;
    endcase
  end

  assign busy = (state_reg == FR_SEND);
  assign done = (state_reg == FR_DONE);

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk  (clk),
    .rst_n(rst_n),
    .data (tx_data),
    .valid(tx_valid),
    .ready(tx_ready),
    .tx   (tx)
  );

endmodule
